// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared definitions for the ysyx_25040111 memory arbiter: grant states, size
// codes and the round-robin winner selection used in IDLE.
package ysyx_25040111_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_I  = 2'd1,
        ARB_GNT_LR = 2'd2,
        ARB_GNT_LW = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } arb_owner_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    // On a tie the requester that did not hold the last grant wins; inside the
    // LSU a pending write goes ahead of a pending read.
    function automatic arb_state_e arb_next_grant(
        input logic       m0Req,
        input logic       m1Rd,
        input logic       m1Wr,
        input arb_owner_e last
    );
        logic m1Req;
        m1Req = m1Rd | m1Wr;
        if (m0Req && (!m1Req || last == OWN_M1)) return ARB_GNT_I;
        if (m1Wr) return ARB_GNT_LW;
        if (m1Rd) return ARB_GNT_LR;
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/ysyx_25040111_arb_watchdog.sv
// No-response watchdog: counts enabled cycles since the last clear and flags
// expiry once LIMIT idle cycles have elapsed. LIMIT of 0 disables it.
module ysyx_25040111_arb_watchdog #(
    parameter int unsigned LIMIT = 1023,
    parameter int unsigned CNT_W = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam bit               ACTIVE  = (LIMIT != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             atLimit;

    // A beat arriving in the same cycle counts as a response, so clear wins.
    always_comb begin
        atLimit  = (cnt_q == LIMIT_C);
        expire_o = ACTIVE && enable_i && !clear_i && atLimit;
        cnt_d    = cnt_q;
        if (!enable_i || clear_i) begin
            cnt_d = '0;
        end else if (!atLimit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Two-master arbiter sharing the downstream memory port between the icache
// refill path (M0, bursts) and the LSU (M1, single beats), round-robin fair.
module ysyx_25040111_mem_arbiter
    import ysyx_25040111_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_rvalid,
    input  logic [31:0] m0_raddr,
    input  logic [7:0]  m0_rlen,
    input  logic        m0_burst,
    output logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic        m0_rlast,
    output logic        m0_err,

    input  logic        m1_rvalid,
    input  logic [31:0] m1_raddr,
    input  logic [1:0]  m1_rmask,
    output logic        m1_rready,
    output logic [31:0] m1_rdata,
    input  logic        m1_wvalid,
    input  logic [31:0] m1_waddr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_wmask,
    output logic        m1_wready,
    output logic        m1_err,

    output logic        s_rvalid,
    output logic [31:0] s_raddr,
    output logic [7:0]  s_rlen,
    output logic        s_burst,
    output logic [1:0]  s_rmask,
    input  logic        s_rready,
    input  logic [31:0] s_rdata,
    output logic        s_wvalid,
    output logic [31:0] s_waddr,
    output logic [31:0] s_wdata,
    output logic [1:0]  s_wmask,
    input  logic        s_wready
);

    arb_state_e state_q, state_d;
    arb_owner_e lastGrant_q, lastGrant_d;
    logic [7:0] beatCnt_q, beatCnt_d;
    logic       inGrant;
    logic       beat;
    logic       expire;
    logic       respOk;

    assign inGrant = (state_q != ARB_IDLE);
    assign beat    = ((state_q == ARB_GNT_I || state_q == ARB_GNT_LR) && s_rready)
                   || (state_q == ARB_GNT_LW && s_wready);
    assign respOk  = !expire && !reset;

    ysyx_25040111_arb_watchdog #(
        .LIMIT (TIMEOUT),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .enable_i (inGrant),
        .clear_i  (beat),
        .expire_o (expire)
    );

    // Every grant falls back to IDLE, which guarantees the one-cycle bubble
    // between consecutive grants and lets IDLE re-arbitrate.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        beatCnt_d   = beatCnt_q;
        case (state_q)
            ARB_IDLE: begin
                state_d = arb_next_grant(m0_rvalid, m1_rvalid, m1_wvalid, lastGrant_q);
                if (state_d == ARB_GNT_I) begin
                    lastGrant_d = OWN_M0;
                    beatCnt_d   = m0_rlen;
                end else if (state_d != ARB_IDLE) begin
                    lastGrant_d = OWN_M1;
                end
            end
            ARB_GNT_I: begin
                if (expire) begin
                    state_d = ARB_IDLE;
                end else if (s_rready) begin
                    if (beatCnt_q == 8'd0) begin
                        state_d = ARB_IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q - 8'd1;
                    end
                end
            end
            ARB_GNT_LR: begin
                if (expire || s_rready) state_d = ARB_IDLE;
            end
            ARB_GNT_LW: begin
                if (expire || s_wready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Only the grantee sees the downstream port; everything else reads zero.
    always_comb begin
        s_rvalid  = 1'b0;
        s_raddr   = '0;
        s_rlen    = '0;
        s_burst   = 1'b0;
        s_rmask   = '0;
        s_wvalid  = 1'b0;
        s_waddr   = '0;
        s_wdata   = '0;
        s_wmask   = '0;
        m0_rready = 1'b0;
        m0_rdata  = '0;
        m0_rlast  = 1'b0;
        m0_err    = 1'b0;
        m1_rready = 1'b0;
        m1_rdata  = '0;
        m1_wready = 1'b0;
        m1_err    = 1'b0;
        case (state_q)
            ARB_GNT_I: begin
                s_rvalid  = 1'b1;
                s_raddr   = m0_raddr;
                s_rlen    = m0_rlen;
                s_burst   = m0_burst;
                s_rmask   = SZ_W;
                m0_rready = s_rready && respOk;
                m0_rdata  = s_rdata;
                m0_rlast  = m0_rready && (beatCnt_q == 8'd0);
                m0_err    = expire && !reset;
            end
            ARB_GNT_LR: begin
                s_rvalid  = 1'b1;
                s_raddr   = m1_raddr;
                s_rmask   = m1_rmask;
                m1_rready = s_rready && respOk;
                m1_rdata  = s_rdata;
                m1_err    = expire && !reset;
            end
            ARB_GNT_LW: begin
                s_wvalid  = 1'b1;
                s_waddr   = m1_waddr;
                s_wdata   = m1_wdata;
                s_wmask   = m1_wmask;
                m1_wready = s_wready && respOk;
                m1_err    = expire && !reset;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            lastGrant_q <= OWN_M1;
            beatCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            beatCnt_q   <= beatCnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Self-checking bench for the memory arbiter: directed scenarios plus random
// rounds, with the bench acting as both requesters and the downstream slave.
module tb_ysyx_25040111_mem_arbiter;

    localparam int unsigned TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_rvalid, m0_burst, m0_rready, m0_rlast, m0_err;
    logic [31:0] m0_raddr, m0_rdata;
    logic [7:0]  m0_rlen;
    logic        m1_rvalid, m1_rready, m1_wvalid, m1_wready, m1_err;
    logic [31:0] m1_raddr, m1_rdata, m1_waddr, m1_wdata;
    logic [1:0]  m1_rmask, m1_wmask;
    logic        s_rvalid, s_burst, s_rready, s_wvalid, s_wready;
    logic [31:0] s_raddr, s_rdata, s_waddr, s_wdata;
    logic [7:0]  s_rlen;
    logic [1:0]  s_rmask, s_wmask;

    int checkCount = 0;
    int errorCount = 0;
    bit lastWasM1  = 1'b1;

    always #5 clock = ~clock;

    ysyx_25040111_mem_arbiter #(
        .TIMEOUT (TO),
        .CNT_W   (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_rvalid (m0_rvalid),
        .m0_raddr  (m0_raddr),
        .m0_rlen   (m0_rlen),
        .m0_burst  (m0_burst),
        .m0_rready (m0_rready),
        .m0_rdata  (m0_rdata),
        .m0_rlast  (m0_rlast),
        .m0_err    (m0_err),
        .m1_rvalid (m1_rvalid),
        .m1_raddr  (m1_raddr),
        .m1_rmask  (m1_rmask),
        .m1_rready (m1_rready),
        .m1_rdata  (m1_rdata),
        .m1_wvalid (m1_wvalid),
        .m1_waddr  (m1_waddr),
        .m1_wdata  (m1_wdata),
        .m1_wmask  (m1_wmask),
        .m1_wready (m1_wready),
        .m1_err    (m1_err),
        .s_rvalid  (s_rvalid),
        .s_raddr   (s_raddr),
        .s_rlen    (s_rlen),
        .s_burst   (s_burst),
        .s_rmask   (s_rmask),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_wvalid  (s_wvalid),
        .s_waddr   (s_waddr),
        .s_wdata   (s_wdata),
        .s_wmask   (s_wmask),
        .s_wready  (s_wready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Grant kinds: 0 icache burst read, 1 LSU read, 2 LSU write, -1 nobody.
    function automatic int pickGrant(input bit p0, input bit p1r, input bit p1w, input bit lastM1);
        if (p0 && (!(p1r || p1w) || lastM1)) return 0;
        if (p1w) return 2;
        if (p1r) return 1;
        return -1;
    endfunction

    task automatic resetDut();
        reset     = 1'b1;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m1_wvalid = 1'b0;
        s_rready  = 1'b0;
        s_wready  = 1'b0;
        s_rdata   = '0;
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        lastWasM1 = 1'b1;
    endtask

    task automatic randomFields();
        logic [1:0] sizes [3];
        sizes     = '{2'b00, 2'b01, 2'b11};
        m0_raddr  = $urandom & 32'hFFFF_FFFC;
        m0_rlen   = 8'($urandom_range(0, 7));
        m0_burst  = 1'b1;
        m1_raddr  = $urandom;
        m1_rmask  = sizes[$urandom_range(0, 2)];
        m1_waddr  = $urandom;
        m1_wdata  = $urandom;
        m1_wmask  = sizes[$urandom_range(0, 2)];
    endtask

    // One cycle in which the arbiter must be idle; stray acks must not leak.
    task automatic checkIdle(input string tag, input bit forceStray);
        s_rready = forceStray | 1'($urandom_range(0, 1));
        s_wready = forceStray | 1'($urandom_range(0, 1));
        s_rdata  = $urandom;
        #1;
        checkOutput({tag, "_valid"}, {s_rvalid, s_wvalid}, 0);
        checkOutput({tag, "_resp"}, {m0_rready, m0_rlast, m0_err, m1_rready, m1_wready, m1_err}, 0);
        checkOutput({tag, "_data"}, m0_rdata | m1_rdata, 0);
        @(negedge clock);
        s_rready = 1'b0;
        s_wready = 1'b0;
    endtask

    task automatic checkGrantFields(input int kind);
        case (kind)
            0: begin
                checkOutput("s_rd_ctl", {s_rvalid, s_rlen, s_burst}, {1'b1, m0_rlen, m0_burst});
                checkOutput("s_raddr", s_raddr, m0_raddr);
                checkOutput("s_wr_off", {s_wvalid, s_wmask} | s_waddr | s_wdata, 0);
            end
            1: begin
                checkOutput("s_rd_ctl", {s_rvalid, s_rlen, s_burst, s_rmask}, {1'b1, 8'd0, 1'b0, m1_rmask});
                checkOutput("s_raddr", s_raddr, m1_raddr);
                checkOutput("s_wr_off", {s_wvalid, s_wmask} | s_waddr | s_wdata, 0);
            end
            default: begin
                checkOutput("s_wr_ctl", {s_wvalid, s_wmask}, {1'b1, m1_wmask});
                checkOutput("s_waddr", s_waddr, m1_waddr);
                checkOutput("s_wdata", s_wdata, m1_wdata);
                checkOutput("s_rd_off", {s_rvalid, s_rlen, s_burst, s_rmask} | s_raddr, 0);
            end
        endcase
    endtask

    // Act as the downstream slave for one grant, from its first cycle to its
    // final beat; the finished requester then withdraws its request.
    task automatic serveGrant(input int kind, input bit randomGaps);
        int          beats;
        int          gap;
        logic [31:0] data;
        beats = (kind == 0) ? int'(m0_rlen) + 1 : 1;
        for (int b = 0; b < beats; b++) begin
            gap = randomGaps ? int'($urandom_range(0, 3)) : 1;
            for (int g = 0; g < gap; g++) begin
                s_rready = 1'b0;
                s_wready = 1'b0;
                s_rdata  = $urandom;
                #1;
                checkGrantFields(kind);
                checkOutput("gapResp", {m0_rready, m0_rlast, m0_err, m1_rready, m1_wready, m1_err}, 0);
                @(negedge clock);
            end
            data = $urandom;
            if (kind == 2) begin
                s_wready = 1'b1;
            end else begin
                s_rready = 1'b1;
                s_rdata  = data;
            end
            #1;
            checkGrantFields(kind);
            case (kind)
                0: begin
                    checkOutput("m0Beat", {m0_rready, m0_rlast, m0_err, m1_rready, m1_wready, m1_err},
                                {1'b1, (b == beats - 1), 4'b0000});
                    checkOutput("m0Data", m0_rdata, data);
                    checkOutput("m1DataOff", m1_rdata, 0);
                end
                1: begin
                    checkOutput("m1RdBeat", {m0_rready, m0_rlast, m0_err, m1_rready, m1_wready, m1_err}, 6'b000100);
                    checkOutput("m1Data", m1_rdata, data);
                    checkOutput("m0DataOff", m0_rdata, 0);
                end
                default: begin
                    checkOutput("m1WrAck", {m0_rready, m0_rlast, m0_err, m1_rready, m1_wready, m1_err}, 6'b000010);
                    checkOutput("wrDataOff", m0_rdata | m1_rdata, 0);
                end
            endcase
            @(negedge clock);
        end
        s_rready = 1'b0;
        s_wready = 1'b0;
        case (kind)
            0:       m0_rvalid = 1'b0;
            1:       m1_rvalid = 1'b0;
            default: m1_wvalid = 1'b0;
        endcase
        lastWasM1 = (kind != 0);
    endtask

    // Raise the given requests together and serve grants in the predicted
    // order until nothing is pending; M0 may re-request during a bubble.
    task automatic applyStimulus(input bit p0, input bit p1r, input bit p1w, input int reM0, input bit randomGaps);
        int k;
        int left;
        left      = reM0;
        m0_rvalid = p0;
        m1_rvalid = p1r;
        m1_wvalid = p1w;
        checkIdle("reqCycle", 1'b0);
        for (int n = 0; n < 8; n++) begin
            k = pickGrant(m0_rvalid, m1_rvalid, m1_wvalid, lastWasM1);
            if (k < 0) break;
            serveGrant(k, randomGaps);
            if (k == 0 && left > 0) begin
                left--;
                m0_rvalid = 1'b1;
                m0_raddr  = $urandom & 32'hFFFF_FFFC;
                m0_rlen   = 8'($urandom_range(0, 7));
            end
            checkIdle("bubble", 1'b0);
        end
    endtask

    initial begin
        randomFields();
        resetDut();
        #1;
        checkOutput("rstResp", {s_rvalid, s_wvalid, m0_rready, m0_rlast, m0_err, m1_rready, m1_wready, m1_err}, 0);
        checkOutput("rstBus", s_raddr | s_waddr | s_wdata | m0_rdata | m1_rdata, 0);
        checkOutput("rstCtl", {s_rlen, s_burst, s_rmask, s_wmask}, 0);
        @(negedge clock);

        // Icache burst alone, downstream beat every other cycle
        m0_raddr = 32'h3000_0000;
        m0_rlen  = 8'd3;
        m0_burst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Simultaneous icache and LSU read; icache re-requests in the bubble
        resetDut();
        randomFields();
        applyStimulus(1'b1, 1'b1, 1'b0, 1, 1'b1);

        // LSU write beats its own simultaneous read
        randomFields();
        m1_waddr = 32'h8000_0010;
        m1_wdata = 32'hDEAD_BEEF;
        m1_wmask = 2'b11;
        applyStimulus(1'b0, 1'b1, 1'b1, 0, 1'b1);

        // Watchdog abort on an LSU read that never gets data
        resetDut();
        m1_raddr  = 32'h1000_0040;
        m1_rmask  = 2'b01;
        m1_rvalid = 1'b1;
        checkIdle("toReq", 1'b0);
        for (int c = 0; c < int'(TO); c++) begin
            #1;
            checkOutput("toWait", {s_rvalid, m1_rready, m1_err, m0_err}, 4'b1000);
            @(negedge clock);
        end
        #1;
        checkOutput("toErr", {m1_rready, m1_err, m0_err}, 3'b010);
        @(negedge clock);
        m1_rvalid = 1'b0;
        lastWasM1 = 1'b1;
        checkIdle("toStray", 1'b1);
        checkIdle("toStray2", 1'b1);

        // Reset in the middle of an 8-beat burst
        resetDut();
        m0_raddr  = 32'h3000_0100;
        m0_rlen   = 8'd7;
        m0_burst  = 1'b1;
        m0_rvalid = 1'b1;
        checkIdle("rsReq", 1'b0);
        for (int b = 0; b < 2; b++) begin
            s_rready = 1'b1;
            s_rdata  = $urandom;
            #1;
            checkOutput("rsBeat", {m0_rready, m0_rlast}, 2'b10);
            @(negedge clock);
        end
        s_rready  = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        m0_rvalid = 1'b0;
        lastWasM1 = 1'b1;
        checkIdle("rsIdle", 1'b1);
        randomFields();
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1);

        // Random request mixes
        for (int r = 0; r < 25; r++) begin
            bit a, b, c;
            randomFields();
            {a, b, c} = 3'($urandom_range(1, 7));
            applyStimulus(a, b, c, int'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_mem_arbiter.md
Name: ysyx_25040111_mem_arbiter

Overview:
- Shares the single downstream memory port between two requesters:
  - M0: the icache refill port (burst reads only).
  - M1: the LSU (single-beat reads and writes).
- Sits between the icache/LSU-side request logic and the bus bridge.
- Registered grant FSM with round-robin fairness, a per-grant burst beat counter and a no-response watchdog.

Parameters:
TIMEOUT, 1023, cycles a grant may wait for any downstream beat/ack before aborting with error; 0 disables the watchdog
CNT_W, 10, width of the watchdog counter; must satisfy TIMEOUT < 2**CNT_W

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_rvalid  in  1  icache read request; held with address stable until its last beat
m0_raddr  in  32  icache read address
m0_rlen  in  8  beats minus one
m0_burst  in  1  incrementing burst
m0_rready  out  1  one pulse per returned beat
m0_rdata  out  32  beat data, valid when m0_rready
m0_rlast  out  1  final beat of the grant
m0_err  out  1  one-cycle error pulse (watchdog abort)
m1_rvalid  in  1  LSU read request
m1_raddr  in  32  LSU read address
m1_rmask  in  2  size code: 00 byte, 01 half, 11 word
m1_rready  out  1  read data pulse
m1_rdata  out  32  read data
m1_wvalid  in  1  LSU write request
m1_waddr  in  32  LSU write address
m1_wdata  in  32  LSU write data
m1_wmask  in  2  LSU write size code
m1_wready  out  1  write acknowledge pulse
m1_err  out  1  one-cycle error pulse
s_rvalid  out  1  downstream read request
s_raddr  out  32  downstream read address
s_rlen  out  8  downstream beats minus one
s_burst  out  1  downstream burst flag
s_rmask  out  2  downstream read size code
s_rready  in  1  downstream read beat strobe
s_rdata  in  32  downstream read beat data
s_wvalid  out  1  downstream write request
s_waddr  out  32  downstream write address
s_wdata  out  32  downstream write data
s_wmask  out  2  downstream write size code
s_wready  in  1  downstream write acknowledge

Behaviour:

FSM states: IDLE, GNT_I, GNT_LR, GNT_LW. The state is registered; all outputs decode combinationally from the state.

Reset:
- State goes to IDLE, last_grant goes to M1 (so M0 wins the first tie), beat counter and watchdog clear to 0.
- All valid, ready, last and err outputs are 0; data and address outputs are 0.

Arbitration in IDLE:
- Requests are sampled each cycle; the next state is registered. Downstream valid therefore rises exactly 1 cycle after the request.
- Winner selection:
  - Only M0 requesting: grant M0.
  - Only M1 requesting: grant M1.
  - Both requesting: grant the one that was not last_grant.
- Within M1, a write (GNT_LW) wins over a simultaneous read (GNT_LR).
- last_grant updates on entry to a grant state.

Beat counter:
- Loaded with m0_rlen on entry to GNT_I.
- Decremented on each s_rready.
- In GNT_I, m0_rlast = s_rready & (cnt == 0).
- For GNT_LR, rlen is forced to 0 and burst to 0.

Grant states:
- Only the granted requester's request is forwarded: s_rvalid/s_wvalid plus its address, size, len and burst.
- All other s_* outputs are 0.
- The granted requester's ready/data mirror s_rready/s_rdata (read) or s_wready (write). Ungranted ready and data outputs are 0.

Release:
- GNT_I returns to IDLE on the cycle after the last beat.
- GNT_LR returns to IDLE on the cycle after s_rready.
- GNT_LW returns to IDLE on the cycle after s_wready.
- Exactly one IDLE bubble between consecutive grants; no back-to-back grant.

Watchdog:
- Counts cycles in a grant state, clears on every beat/ack.
- On reaching TIMEOUT: pulse the grantee's err for 1 cycle, assert no ready, go to IDLE.
- Late s_rready/s_wready arriving in IDLE is ignored and never forwarded.

Illegal request changes and reset:
- Requester drops valid mid-grant: this is illegal; the arbiter keeps the grant until completion or timeout.
- Reset asserted mid-burst: return to IDLE next edge, with no further ready pulses.

Decomposition:
- Shared package (existing ysyx_25040111 defines file):
  - State encodings ARB_IDLE=2'd0, ARB_GNT_I=2'd1, ARB_GNT_LR=2'd2, ARB_GNT_LW=2'd3.
  - Size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b11.
- Sub-module: ysyx_25040111_arb_watchdog (CNT_W counter with clear/enable inputs and expire output). It is reused by the future uart/clint bridge.

Test Plan:
1. M0 alone, raddr=0x3000_0000, rlen=3, burst=1, s_rready every other cycle → s_rvalid rises 1 cycle after request; 4 m0_rready pulses; m0_rlast only on the 4th; back to IDLE the cycle after.
2. M0 and M1-read asserted on the same cycle after reset → M0 granted first; M1 granted after M0's last beat plus 1 IDLE cycle. A repeat simultaneous request then grants M1 first (round-robin).
3. M1 write 0x8000_0010 / data 0xDEADBEEF / mask 2'b11 with m1_rvalid also high → GNT_LW first; s_wdata=0xDEADBEEF; m1_wready mirrors s_wready; the read is served next.
4. TIMEOUT=8, M1 read, s_rready never asserted → m1_err high exactly 1 cycle after 8 grant cycles; a later stray s_rready produces no m1_rready.
5. Reset asserted after beat 2 of an rlen=7 burst → next cycle all s_*valid=0, state IDLE, no m0_rready; a new M1 request is served normally.
